elevator_sched: RTL and testbench

Elevator car scheduler for the door/motor datapath. It latches floor calls and picks the travel direction with a SCAN (sweep) policy. It sequences door close, floor-to-floor travel, arrival and door dwell, and drives the door line with the codebase door encoding (0 = open, 1 = closed). It sits above the door FSM and motor drivers and is the only block that decides when the car moves.

---
 rtl/elevator_pkg.sv | 8 +
 rtl/elevator_scan.sv | 35 +++
 rtl/elevator_sched.sv | 139 +++++++++++++
 tb/tb_elevator_sched.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// rtl/elevator_pkg.sv - shared door, state and direction encodings for the elevator scheduler
package elevator_pkg;
    localparam logic DOOR_OPEN   = 1'b0;
    localparam logic DOOR_CLOSED = 1'b1;

    typedef enum logic [1:0] {IDLE, CLOSE, MOVE, DWELL} state_t;
    typedef enum logic {UP = 1'b0, DN = 1'b1} dir_t;
endpackage

// File: rtl/elevator_scan.sv
// rtl/elevator_scan.sv - SCAN direction choice from pending calls, floor and current direction
module elevator_scan import elevator_pkg::*; #(
    parameter int FLOORS  = 4,
    parameter int FLOOR_W = 2
) (
    input  logic [FLOORS-1:0]  pending,
    input  logic [FLOOR_W-1:0] floor,
    input  dir_t               dir,
    output dir_t               next_dir,
    output logic               any_ahead,
    output logic               any_behind
);
    logic above;
    logic below;

    always_comb begin
        above = 1'b0;
        below = 1'b0;
        for (int i = 0; i < FLOORS; i++) begin
            if (FLOOR_W'(i) > floor) above = above | pending[i];
            if (FLOOR_W'(i) < floor) below = below | pending[i];
        end
        any_ahead  = (dir == UP) ? above : below;
        any_behind = (dir == UP) ? below : above;

        // End floors pin the direction so the car can never run off the shaft.
        next_dir = dir;
        if (floor == '0)
            next_dir = UP;
        else if (floor == FLOOR_W'(FLOORS - 1))
            next_dir = DN;
        else if (!any_ahead && any_behind)
            next_dir = (dir == UP) ? DN : UP;
    end
endmodule

// File: rtl/elevator_sched.sv
// rtl/elevator_sched.sv - elevator car scheduler: call latch, SCAN travel, door close/dwell sequencing
module elevator_sched import elevator_pkg::*; #(
    parameter int FLOORS        = 4,
    parameter int FLOOR_W       = 2,
    parameter int TRAVEL_CYCLES = 8,
    parameter int DWELL_CYCLES  = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [FLOORS-1:0]  call_btn,
    input  logic               alarm,
    output logic               door,
    output logic               motor_up,
    output logic               motor_down,
    output logic [FLOOR_W-1:0] floor,
    output logic [FLOORS-1:0]  pending,
    output logic               busy
);
    localparam int CNT_MAX = (TRAVEL_CYCLES > DWELL_CYCLES) ? TRAVEL_CYCLES : DWELL_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] TRAVEL_LOAD = CNT_W'(TRAVEL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DWELL_LOAD  = CNT_W'(DWELL_CYCLES - 1);

    state_t             state;
    dir_t               dir;
    dir_t               next_dir;
    logic [CNT_W-1:0]   cnt;
    logic [FLOOR_W-1:0] next_floor;
    logic [FLOOR_W-1:0] scan_floor;
    logic [FLOORS-1:0]  floor_mask;
    logic [FLOORS-1:0]  next_mask;
    logic [FLOORS-1:0]  clear_mask;
    logic               any_ahead;
    logic               any_behind;
    logic               arrive;

    always_comb begin
        next_floor = floor;
        if (dir == UP && floor != FLOOR_W'(FLOORS - 1))
            next_floor = floor + 1'b1;
        else if (dir == DN && floor != '0)
            next_floor = floor - 1'b1;
    end

    // While travelling, the direction is re-evaluated from the floor about to be reached.
    assign scan_floor = (state == MOVE) ? next_floor : floor;
    assign floor_mask = FLOORS'(1) << floor;
    assign next_mask  = FLOORS'(1) << next_floor;
    assign arrive     = (state == MOVE) && !alarm && (cnt == '0);

    elevator_scan #(
        .FLOORS  (FLOORS),
        .FLOOR_W (FLOOR_W)
    ) u_scan (
        .pending    (pending),
        .floor      (scan_floor),
        .dir        (dir),
        .next_dir   (next_dir),
        .any_ahead  (any_ahead),
        .any_behind (any_behind)
    );

    always_comb begin
        clear_mask = '0;
        case (state)
            IDLE:    if (!alarm && pending[floor]) clear_mask = floor_mask;
            MOVE:    if (arrive && pending[next_floor]) clear_mask = next_mask;
            DWELL:   clear_mask = floor_mask;
            default: clear_mask = '0;
        endcase
    end

    // Motors follow the registered state but drop in the same cycle an alarm is raised.
    assign motor_up   = (state == MOVE) && (dir == UP) && !alarm;
    assign motor_down = (state == MOVE) && (dir == DN) && !alarm;
    assign busy       = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            dir     <= UP;
            floor   <= '0;
            pending <= '0;
            door    <= DOOR_OPEN;
            cnt     <= '0;
        end else begin
            pending <= (pending | call_btn) & ~clear_mask;
            case (state)
                IDLE: begin
                    if (!alarm) begin
                        if (pending[floor]) begin
                            state <= DWELL;
                            cnt   <= DWELL_LOAD;
                        end else if (|pending) begin
                            state <= CLOSE;
                            door  <= DOOR_CLOSED;
                        end
                    end
                end
                CLOSE: begin
                    if (!alarm && (any_ahead || any_behind)) begin
                        state <= MOVE;
                        dir   <= next_dir;
                        cnt   <= TRAVEL_LOAD;
                    end else begin
                        state <= IDLE;
                        door  <= DOOR_OPEN;
                    end
                end
                MOVE: begin
                    if (!alarm) begin
                        if (cnt != '0) begin
                            cnt <= cnt - 1'b1;
                        end else begin
                            floor <= next_floor;
                            if (pending[next_floor]) begin
                                state <= DWELL;
                                door  <= DOOR_OPEN;
                                cnt   <= DWELL_LOAD;
                            end else begin
                                dir <= next_dir;
                                cnt <= TRAVEL_LOAD;
                            end
                        end
                    end
                end
                DWELL: begin
                    if (alarm || call_btn[floor])
                        cnt <= DWELL_LOAD;
                    else if (cnt == '0)
                        state <= IDLE;
                    else
                        cnt <= cnt - 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_elevator_sched.sv
// tb/tb_elevator_sched.sv - directed self-checking bench for elevator_sched
module tb_elevator_sched;
    logic       clk;
    logic       reset;
    logic [3:0] call_btn;
    logic       alarm;
    logic       door;
    logic       motor_up;
    logic       motor_down;
    logic [1:0] floor;
    logic [3:0] pending;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int viol = 0;
    int motor_cycles = 0;
    int max_floor = 0;

    elevator_sched #(
        .FLOORS        (4),
        .FLOOR_W       (2),
        .TRAVEL_CYCLES (8),
        .DWELL_CYCLES  (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .call_btn   (call_btn),
        .alarm      (alarm),
        .door       (door),
        .motor_up   (motor_up),
        .motor_down (motor_down),
        .floor      (floor),
        .pending    (pending),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (motor_up && motor_down) viol++;
        if ((motor_up || motor_down) && door == 1'b0) viol++;
        if (motor_up || motor_down) motor_cycles++;
        if (int'(floor) > max_floor) max_floor = int'(floor);
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        reset = 1'b1;
        call_btn = 4'b0000;
        alarm = 1'b0;
        tick_n(2);
        reset = 1'b0;
        check("rst_floor", floor, 0);
        check("rst_door", door, 0);
        check("rst_motor_up", motor_up, 0);
        check("rst_motor_down", motor_down, 0);
        check("rst_pending", pending, 0);
        check("rst_busy", busy, 0);

        // One call two floors up from floor 0.
        call_btn = 4'b0100;
        tick();
        call_btn = 4'b0000;
        check("s1_pending", pending, 4'b0100);
        check("s1_idle", busy, 0);
        tick();
        check("s1_close_busy", busy, 1);
        check("s1_close_door", door, 1);
        check("s1_close_motor", motor_up, 0);
        tick();
        check("s1_move_up", motor_up, 1);
        check("s1_move_down", motor_down, 0);
        tick_n(7);
        check("s1_floor_before_1", floor, 0);
        tick();
        check("s1_floor_1", floor, 1);
        check("s1_pass_motor", motor_up, 1);
        tick_n(7);
        check("s1_floor_before_2", floor, 1);
        tick();
        check("s1_floor_2", floor, 2);
        check("s1_arrive_door", door, 0);
        check("s1_arrive_pending", pending, 0);
        check("s1_arrive_motor", motor_up, 0);
        tick_n(3);
        check("s1_dwell_busy", busy, 1);
        tick();
        check("s1_back_idle", busy, 0);

        // Same-floor call at floor 0 goes straight to dwell.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        motor_cycles = 0;
        call_btn = 4'b0001;
        tick();
        call_btn = 4'b0000;
        check("s2_pending", pending, 4'b0001);
        tick();
        check("s2_dwell_busy", busy, 1);
        check("s2_door", door, 0);
        check("s2_cleared", pending, 0);
        tick_n(3);
        check("s2_dwell_end", busy, 1);
        tick();
        check("s2_idle", busy, 0);
        check("s2_no_motor", motor_cycles, 0);

        // Sweep up to floor 3, then reverse down to floor 0.
        max_floor = 0;
        call_btn = 4'b1000;
        tick();
        call_btn = 4'b0000;
        tick_n(2);
        check("s3_up", motor_up, 1);
        tick_n(8);
        check("s3_floor_1", floor, 1);
        call_btn = 4'b0001;
        tick();
        call_btn = 4'b0000;
        check("s3_pending", pending, 4'b1001);
        tick_n(15);
        check("s3_floor_3", floor, 3);
        check("s3_door_3", door, 0);
        check("s3_pending_3", pending, 4'b0001);
        tick_n(4);
        check("s3_idle_3", busy, 0);
        tick_n(2);
        check("s3_down", motor_down, 1);
        check("s3_down_up", motor_up, 0);
        tick_n(24);
        check("s3_floor_0", floor, 0);
        check("s3_door_0", door, 0);
        check("s3_pending_0", pending, 0);
        check("s3_max_floor", max_floor, 3);
        tick_n(4);

        // Alarm for 5 cycles between floors 1 and 2.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        call_btn = 4'b0100;
        tick();
        call_btn = 4'b0000;
        tick_n(10);
        check("s4_floor_1", floor, 1);
        tick_n(3);
        alarm = 1'b1;
        #1;
        check("s4_alarm_up", motor_up, 0);
        check("s4_alarm_down", motor_down, 0);
        check("s4_alarm_door", door, 1);
        tick_n(5);
        check("s4_frozen_floor", floor, 1);
        check("s4_frozen_door", door, 1);
        alarm = 1'b0;
        #1;
        check("s4_resume", motor_up, 1);
        tick_n(4);
        check("s4_not_yet", floor, 1);
        tick();
        check("s4_floor_2", floor, 2);
        check("s4_door_open", door, 0);

        // Alarm held through dwell stretches the open-door time.
        alarm = 1'b1;
        tick_n(10);
        alarm = 1'b0;
        check("s5_alarm_dwell", busy, 1);
        tick_n(3);
        check("s5_dwell_tail", busy, 1);
        check("s5_dwell_door", door, 0);
        tick();
        check("s5_idle", busy, 0);

        // A same-floor press during dwell restarts it and is not latched.
        call_btn = 4'b0100;
        tick();
        call_btn = 4'b0000;
        tick();
        check("s5_dwell2", busy, 1);
        tick();
        call_btn = 4'b0100;
        tick();
        call_btn = 4'b0000;
        check("s5_absorbed", pending, 0);
        tick_n(3);
        check("s5_restart", busy, 1);
        tick();
        check("s5_idle2", busy, 0);

        // Reset mid-travel drops calls and parks the car.
        call_btn = 4'b1000;
        tick();
        call_btn = 4'b0000;
        tick_n(4);
        check("s6_floor", floor, 2);
        check("s6_pending", pending, 4'b1000);
        check("s6_moving", motor_up, 1);
        reset = 1'b1;
        tick();
        check("s6_rst_floor", floor, 0);
        check("s6_rst_door", door, 0);
        check("s6_rst_motor", motor_up, 0);
        check("s6_rst_pending", pending, 0);
        check("s6_rst_busy", busy, 0);
        reset = 1'b0;
        tick_n(2);
        check("s6_stays_idle", busy, 0);

        check("motor_door_invariant", viol, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
